// File: rtl/dcache_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dcache_pkg
// Description : Address field widths and FSM state encodings for dcache_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
package dcache_pkg;

    localparam int OFFSET = 5;
    localparam int INDEX  = 5;
    localparam int TAG    = 22;

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_WRITEBACK = 2'd1;
    localparam logic [1:0] ST_ALLOCATE  = 2'd2;
    localparam logic [1:0] ST_REFILL    = 2'd3;

endpackage : dcache_pkg
`default_nettype wire

// File: rtl/dcache_sram.sv
`default_nettype none
// ============================================================================
// Module      : dcache_sram
// Description : Per-line valid/dirty/tag/data storage, one write port,
//               asynchronous index-addressed read.
// Revision    : 1.0 - initial release
// ============================================================================
module dcache_sram
    import dcache_pkg::*;
#(
    parameter int LINES      = 32,
    parameter int BLOCK_BITS = 256
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [$clog2(LINES)-1:0] rd_index,
    output logic                     rd_valid,
    output logic                     rd_dirty,
    output logic [TAG-1:0]           rd_tag,
    output logic [BLOCK_BITS-1:0]    rd_data,
    input  logic                     wr_en,
    input  logic [$clog2(LINES)-1:0] wr_index,
    input  logic                     wr_valid,
    input  logic                     wr_dirty,
    input  logic [TAG-1:0]           wr_tag,
    input  logic [BLOCK_BITS-1:0]    wr_data
);

    logic [LINES-1:0]      r_valid;
    logic [LINES-1:0]      r_dirty;
    logic [TAG-1:0]        r_tag  [LINES];
    logic [BLOCK_BITS-1:0] r_data [LINES];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
            r_dirty <= '0;
        end else if (wr_en) begin
            r_valid[wr_index] <= wr_valid;
            r_dirty[wr_index] <= wr_dirty;
        end
    end

    // Tag/data contents are meaningless while the valid bit is clear, so no reset.
    always_ff @(posedge clk) begin
        if (!rst && wr_en) begin
            r_tag[wr_index]  <= wr_tag;
            r_data[wr_index] <= wr_data;
        end
    end

    assign rd_valid = r_valid[rd_index];
    assign rd_dirty = r_dirty[rd_index];
    assign rd_tag   = r_tag[rd_index];
    assign rd_data  = r_data[rd_index];

endmodule : dcache_sram
`default_nettype wire

// File: rtl/dcache_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : dcache_ctrl
// Description : Direct-mapped write-back data cache controller with
//               combinational hit detection and a four-state miss FSM.
// Revision    : 1.0 - initial release
// ============================================================================
module dcache_ctrl
    import dcache_pkg::*;
#(
    parameter int LINES      = 32,
    parameter int BLOCK_BITS = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [31:0]           p1_addr_i,
    input  logic [31:0]           p1_data_i,
    input  logic                  p1_MemRead_i,
    input  logic                  p1_MemWrite_i,
    output logic [31:0]           p1_data_o,
    output logic                  p1_stall_o,
    output logic                  mem_enable_o,
    output logic                  mem_write_o,
    output logic [31:0]           mem_addr_o,
    output logic [BLOCK_BITS-1:0] mem_data_o,
    input  logic [BLOCK_BITS-1:0] mem_data_i,
    input  logic                  mem_ack_i
);

    logic [1:0]            r_state;
    logic [1:0]            w_next;
    logic [BLOCK_BITS-1:0] r_refill_buf;

    logic [INDEX-1:0]      w_index;
    logic [TAG-1:0]        w_tag;
    logic [2:0]            w_word;
    logic [7:0]            w_bit_ofs;
    logic                  w_req;
    logic                  w_hit;
    logic                  w_idle;

    logic                  w_line_valid;
    logic                  w_line_dirty;
    logic [TAG-1:0]        w_line_tag;
    logic [BLOCK_BITS-1:0] w_line_data;
    logic [BLOCK_BITS-1:0] w_line_upd;

    logic                  w_wr_en;
    logic                  w_wr_dirty;
    logic [BLOCK_BITS-1:0] w_wr_data;

    assign w_index   = p1_addr_i[OFFSET +: INDEX];
    assign w_tag     = p1_addr_i[OFFSET+INDEX +: TAG];
    assign w_word    = p1_addr_i[4:2];
    assign w_bit_ofs = {w_word, 5'b00000};
    assign w_req     = p1_MemRead_i | p1_MemWrite_i;
    assign w_idle    = (r_state == ST_IDLE);
    assign w_hit     = w_req & w_line_valid & (w_line_tag == w_tag);

    dcache_sram #(
        .LINES      (LINES),
        .BLOCK_BITS (BLOCK_BITS)
    ) u_sram (
        .clk      (clk),
        .rst      (rst),
        .rd_index (w_index),
        .rd_valid (w_line_valid),
        .rd_dirty (w_line_dirty),
        .rd_tag   (w_line_tag),
        .rd_data  (w_line_data),
        .wr_en    (w_wr_en),
        .wr_index (w_index),
        .wr_valid (1'b1),
        .wr_dirty (w_wr_dirty),
        .wr_tag   (w_tag),
        .wr_data  (w_wr_data)
    );

    always_comb begin
        w_line_upd                  = w_line_data;
        w_line_upd[w_bit_ofs +: 32] = p1_data_i;
    end

    // Write hits merge one word and mark dirty; REFILL installs a clean line.
    assign w_wr_en    = (w_idle & w_hit & p1_MemWrite_i) | (r_state == ST_REFILL);
    assign w_wr_dirty = w_idle;
    assign w_wr_data  = w_idle ? w_line_upd : r_refill_buf;

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_req && !w_hit)
                    w_next = (w_line_valid && w_line_dirty) ? ST_WRITEBACK : ST_ALLOCATE;
            end
            ST_WRITEBACK: if (mem_ack_i) w_next = ST_ALLOCATE;
            ST_ALLOCATE:  if (mem_ack_i) w_next = ST_REFILL;
            ST_REFILL:    w_next = ST_IDLE;
            default:      w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_refill_buf <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == ST_ALLOCATE && mem_ack_i)
                r_refill_buf <= mem_data_i;
        end
    end

    assign p1_stall_o   = !w_idle | (w_req & !w_hit);
    assign p1_data_o    = (w_idle && w_hit && p1_MemRead_i && !p1_MemWrite_i)
                          ? w_line_data[w_bit_ofs +: 32] : 32'd0;

    assign mem_enable_o = (r_state == ST_WRITEBACK) | (r_state == ST_ALLOCATE);
    assign mem_write_o  = (r_state == ST_WRITEBACK);

    always_comb begin
        mem_addr_o = 32'd0;
        mem_data_o = '0;
        if (r_state == ST_WRITEBACK) begin
            mem_addr_o = {w_line_tag, w_index, 5'b00000};
            mem_data_o = w_line_data;
        end else if (r_state == ST_ALLOCATE) begin
            mem_addr_o = {p1_addr_i[31:5], 5'b00000};
        end
    end

endmodule : dcache_ctrl
`default_nettype wire

// File: tb/tb_dcache_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_dcache_ctrl
// Description : Directed self-checking bench for dcache_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dcache_ctrl;

    logic         clk;
    logic         rst;
    logic [31:0]  p1_addr_i;
    logic [31:0]  p1_data_i;
    logic         p1_MemRead_i;
    logic         p1_MemWrite_i;
    logic [31:0]  p1_data_o;
    logic         p1_stall_o;
    logic         mem_enable_o;
    logic         mem_write_o;
    logic [31:0]  mem_addr_o;
    logic [255:0] mem_data_o;
    logic [255:0] mem_data_i;
    logic         mem_ack_i;

    int n_checks = 0;
    int n_fails  = 0;

    dcache_ctrl u_dut (
        .clk           (clk),
        .rst           (rst),
        .p1_addr_i     (p1_addr_i),
        .p1_data_i     (p1_data_i),
        .p1_MemRead_i  (p1_MemRead_i),
        .p1_MemWrite_i (p1_MemWrite_i),
        .p1_data_o     (p1_data_o),
        .p1_stall_o    (p1_stall_o),
        .mem_enable_o  (mem_enable_o),
        .mem_write_o   (mem_write_o),
        .mem_addr_o    (mem_addr_o),
        .mem_data_o    (mem_data_o),
        .mem_data_i    (mem_data_i),
        .mem_ack_i     (mem_ack_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] make_block(input logic [31:0] base, input logic [31:0] w0);
        logic [255:0] b;
        for (int k = 0; k < 8; k++) b[k*32 +: 32] = base + 32'(k);
        b[31:0] = w0;
        return b;
    endfunction

    // Cycle through a miss, acking each memory phase after its latency in cycles.
    task automatic run_miss(input logic [255:0] blk, input int lat_wb, input int lat_al,
                            output int stalls, output int wb_cycles,
                            output logic [31:0] wb_addr, output logic [255:0] wb_blk,
                            output logic [31:0] al_addr, output logic al_write);
        int   cnt;
        logic done;
        stalls = 0; wb_cycles = 0; cnt = 0; done = 1'b0;
        wb_addr = '0; wb_blk = '0; al_addr = '0; al_write = 1'b1;
        for (int c = 0; c < 64 && !done; c++) begin
            if (!p1_stall_o) begin
                done = 1'b1;
            end else begin
                stalls++;
                if (mem_enable_o) begin
                    cnt++;
                    if (mem_write_o) begin
                        wb_cycles++;
                        if (cnt == 1) begin wb_addr = mem_addr_o; wb_blk = mem_data_o; end
                        if (cnt == lat_wb) begin mem_ack_i = 1'b1; cnt = 0; end
                    end else begin
                        if (cnt == 1) begin al_addr = mem_addr_o; al_write = mem_write_o; end
                        if (cnt == lat_al) begin mem_ack_i = 1'b1; mem_data_i = blk; cnt = 0; end
                    end
                end
                @(posedge clk);
                @(negedge clk);
                mem_ack_i  = 1'b0;
                mem_data_i = '0;
                #1;
            end
        end
        check("miss_completes", {31'd0, done}, 32'd1);
    endtask

    task automatic drive(input logic rd, input logic wr, input logic [31:0] addr, input logic [31:0] data);
        @(negedge clk);
        p1_MemRead_i  = rd;
        p1_MemWrite_i = wr;
        p1_addr_i     = addr;
        p1_data_i     = data;
        #1;
    endtask

    initial begin
        int           stalls, wb_cycles;
        logic [31:0]  wb_addr, al_addr;
        logic [255:0] wb_blk;
        logic         al_write;
        logic [255:0] blk_a, blk_b, blk_c;

        blk_a = make_block(32'hA0A0_0000, 32'hDEAD_BEEF);
        blk_b = make_block(32'hB0B0_0000, 32'hB0B0_0000);
        blk_c = make_block(32'hC0C0_0000, 32'hC0C0_0000);

        rst = 1'b1; p1_addr_i = '0; p1_data_i = '0; p1_MemRead_i = 1'b0;
        p1_MemWrite_i = 1'b0; mem_data_i = '0; mem_ack_i = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_stall",    {31'd0, p1_stall_o},   32'd0);
        check("rst_mem_en",   {31'd0, mem_enable_o}, 32'd0);
        check("rst_mem_wr",   {31'd0, mem_write_o},  32'd0);
        check("rst_mem_addr", mem_addr_o,            32'd0);
        check("rst_mem_data", mem_data_o[31:0],      32'd0);
        check("rst_p1_data",  p1_data_o,             32'd0);

        // Cold read: 1 miss cycle + 4 ALLOCATE + 1 REFILL.
        drive(1'b1, 1'b0, 32'h0000_0040, 32'd0);
        check("cold_stall_now", {31'd0, p1_stall_o}, 32'd1);
        run_miss(blk_a, 2, 4, stalls, wb_cycles, wb_addr, wb_blk, al_addr, al_write);
        check("cold_stall_cycles", 32'(stalls),      32'd6);
        check("cold_no_wb",        32'(wb_cycles),   32'd0);
        check("cold_alloc_addr",   al_addr,          32'h0000_0040);
        check("cold_alloc_wr",     {31'd0, al_write}, 32'd0);
        check("cold_data",         p1_data_o,        32'hDEAD_BEEF);
        check("cold_stall_low",    {31'd0, p1_stall_o}, 32'd0);

        drive(1'b1, 1'b0, 32'h0000_0044, 32'd0);
        check("hit44_stall", {31'd0, p1_stall_o},   32'd0);
        check("hit44_data",  p1_data_o,             32'hA0A0_0001);
        check("hit44_mem",   {31'd0, mem_enable_o}, 32'd0);

        drive(1'b0, 1'b1, 32'h0000_0048, 32'h1234_5678);
        check("wr48_stall",  {31'd0, p1_stall_o},   32'd0);
        check("wr48_mem",    {31'd0, mem_enable_o}, 32'd0);
        check("wr48_p1data", p1_data_o,             32'd0);

        drive(1'b1, 1'b0, 32'h0000_0048, 32'd0);
        check("rd48_data",  p1_data_o, 32'h1234_5678);
        drive(1'b1, 1'b0, 32'h0000_0040, 32'd0);
        check("rd40_intact", p1_data_o, 32'hDEAD_BEEF);

        // Conflict miss on dirty index 2: writeback then allocate.
        drive(1'b1, 1'b0, 32'h0000_0448, 32'd0);
        run_miss(blk_b, 2, 3, stalls, wb_cycles, wb_addr, wb_blk, al_addr, al_write);
        check("evict_stall_cycles", 32'(stalls),      32'd7);
        check("evict_wb_cycles",    32'(wb_cycles),   32'd2);
        check("evict_wb_addr",      wb_addr,          32'h0000_0040);
        check("evict_wb_word2",     wb_blk[95:64],    32'h1234_5678);
        check("evict_wb_word0",     wb_blk[31:0],     32'hDEAD_BEEF);
        check("evict_alloc_addr",   al_addr,          32'h0000_0440);
        check("evict_alloc_wr",     {31'd0, al_write}, 32'd0);
        check("evict_data",         p1_data_o,        32'hB0B0_0002);

        // Reset while in ALLOCATE.
        drive(1'b1, 1'b0, 32'h0000_0040, 32'd0);
        check("rmiss_stall", {31'd0, p1_stall_o}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        #1;
        check("rmiss_alloc_en",   {31'd0, mem_enable_o}, 32'd1);
        check("rmiss_alloc_wr",   {31'd0, mem_write_o},  32'd0);
        check("rmiss_alloc_addr", mem_addr_o,            32'h0000_0040);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        #1;
        check("rmid_mem_en", {31'd0, mem_enable_o}, 32'd0);
        check("rmid_mem_wr", {31'd0, mem_write_o},  32'd0);
        rst = 1'b0;
        #1;
        check("rmid_miss_again", {31'd0, p1_stall_o}, 32'd1);
        run_miss(blk_c, 2, 4, stalls, wb_cycles, wb_addr, wb_blk, al_addr, al_write);
        check("rmid_stall_cycles", 32'(stalls),    32'd6);
        check("rmid_no_wb",        32'(wb_cycles), 32'd0);
        check("rmid_data",         p1_data_o,      32'hC0C0_0000);

        // Stray ack in IDLE.
        drive(1'b0, 1'b0, 32'h0000_0040, 32'd0);
        mem_ack_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        mem_ack_i = 1'b0;
        #1;
        check("idle_ack_stall", {31'd0, p1_stall_o},   32'd0);
        check("idle_ack_mem",   {31'd0, mem_enable_o}, 32'd0);
        drive(1'b1, 1'b0, 32'h0000_0040, 32'd0);
        check("idle_ack_hit", p1_data_o, 32'hC0C0_0000);

        // Read and write together behave as a write and dirty the line.
        drive(1'b1, 1'b1, 32'h0000_0044, 32'h55AA_55AA);
        check("rw_stall", {31'd0, p1_stall_o}, 32'd0);
        drive(1'b1, 1'b0, 32'h0000_0044, 32'd0);
        check("rw_data", p1_data_o, 32'h55AA_55AA);
        drive(1'b1, 1'b0, 32'h0000_0444, 32'd0);
        run_miss(blk_b, 3, 2, stalls, wb_cycles, wb_addr, wb_blk, al_addr, al_write);
        check("rw_evict_stalls", 32'(stalls),    32'd7);
        check("rw_evict_wb",     32'(wb_cycles), 32'd3);
        check("rw_evict_addr",   wb_addr,        32'h0000_0040);
        check("rw_evict_word1",  wb_blk[63:32],  32'h55AA_55AA);
        check("rw_evict_data",   p1_data_o,      32'hB0B0_0001);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule : tb_dcache_ctrl
`default_nettype wire

// File: doc/dcache_ctrl.md
DCACHE_CTRL -- requirements
Module: dcache_ctrl

Interface
REQ-001 SHALL have the ports listed below; clock and reset come first.
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- p1_addr_i  in  32  MEM-stage byte address.
- p1_data_i  in  32  MEM-stage store data.
- p1_MemRead_i  in  1  load request.
- p1_MemWrite_i  in  1  store request.
- p1_data_o  out  32  load data.
- p1_stall_o  out  1  mem_stall to pipeline registers and PC; 1 = hold.
- mem_enable_o  out  1  off-chip request.
- mem_write_o  out  1  1 = writeback, 0 = fill.
- mem_addr_o  out  32  block-aligned address, low 5 bits 0.
- mem_data_o  out  256  writeback block.
- mem_data_i  in  256  fill block.
- mem_ack_i  in  1  one-cycle completion pulse from memory.
REQ-002 SHALL use the decided clocking and reset: one clock; reset is synchronous and active-high.
REQ-003 SHALL have these parameters:
- LINES, default 32, number of lines.
- BLOCK_BITS, default 256, line size in bits.

Function
REQ-004 SHALL be direct-mapped, with this address split:
- offset = addr[4:0]; word select = addr[4:2].
- index = addr[9:5].
- tag = addr[31:10], 22 bits.
- Each line holds valid, dirty, tag and 256-bit data.
REQ-005 SHALL compute hit combinationally: hit = valid[index] and tag match, qualified by MemRead or MemWrite.
REQ-006 SHALL use FSM states IDLE, WRITEBACK, ALLOCATE, REFILL.
REQ-007 SHALL handle IDLE as follows:
- No request, or a hit: stay in IDLE; p1_stall_o = 0.
- Miss on a clean or invalid line: go to ALLOCATE.
- Miss on a dirty line: go to WRITEBACK.
REQ-008 SHALL drive p1_stall_o combinationally: 1 in the same cycle a miss is detected, and 1 in every non-IDLE state.
REQ-009 SHALL handle WRITEBACK as follows:
- Drive mem_enable_o = 1 and mem_write_o = 1.
- mem_addr_o = {stored tag, index, 5'b0}; mem_data_o = line data.
- On mem_ack_i go to ALLOCATE.
REQ-010 SHALL handle ALLOCATE as follows:
- Drive mem_enable_o = 1 and mem_write_o = 0.
- mem_addr_o = {addr[31:5], 5'b0}.
- On mem_ack_i capture mem_data_i and go to REFILL.
REQ-011 SHALL, in REFILL, write the line (valid = 1, dirty = 0, new tag), then return to IDLE. The request then hits there, so total miss penalty = memory latency(s) + 2 cycles.
REQ-012 SHALL, on a read hit, return p1_data_o = the selected 32-bit word in the same cycle. It is 0 when no read is requested.
REQ-013 SHALL, on a write hit, update only the selected word at the clock edge and set dirty = 1.
REQ-014 SHALL hold mem_enable_o high, with stable address and data, until mem_ack_i. It is 0 in IDLE and REFILL.
REQ-015 SHALL ignore mem_ack_i in IDLE and REFILL.
REQ-016 SHALL treat MemRead and MemWrite both high as a write.
REQ-017 SHALL hold the pipeline address stable while p1_stall_o = 1 (guaranteed by the stalled pipeline). The controller does not latch the address.

Reset
REQ-018 SHALL, while rst = 1 at a rising edge:
- Set state = IDLE.
- Clear all valid and dirty bits.
- Clear the refill buffer.
REQ-019 SHALL, after reset, drive p1_stall_o, mem_enable_o and mem_write_o to 0. mem_addr_o, mem_data_o and p1_data_o are 0 when no request is present.
REQ-020 SHALL, on reset mid-miss (any state), abandon the transaction and drop mem_enable_o the next cycle. The pending line is not written.

Structure
REQ-021 SHALL place state encodings and the address field widths (OFFSET = 5, INDEX = 5, TAG = 22) in a shared package, dcache_pkg.
REQ-022 SHALL keep tag, valid, dirty and data storage in one sub-module, dcache_sram: index-addressed, single write port, asynchronous read. The FSM and hit logic stay in dcache_ctrl.

Verification
REQ-023 SHALL cover these directed scenarios:
- Cold read of 0x0000_0040, memory acks after 4 cycles with a block whose word 0 = 0xDEADBEEF:
  - stall high for exactly 6 cycles;
  - then p1_data_o = 0xDEADBEEF with stall low.
- Read of 0x0000_0044 right after that: hit, no stall, word 1 of the same block returned.
- Write 0x12345678 to 0x0000_0048 (hit):
  - no stall, no memory request;
  - a following read returns 0x12345678.
- Read of 0x0000_0448 (same index 2, new tag, line dirty):
  - WRITEBACK with mem_write_o = 1 and mem_addr_o = 0x0000_0040, mem_data_o word 2 = 0x12345678;
  - then ALLOCATE at 0x0000_0440.
- rst asserted during ALLOCATE:
  - next cycle state IDLE, mem_enable_o = 0;
  - a read of 0x0000_0040 misses again.
- mem_ack_i pulsed while in IDLE: no state change, no stall.
